uart_byte_tx: RTL and testbench

//  Serial UART transmitter, downstream of the protocol TX framer.
//  - Consumes the framer's START_OUT/DATA_OUT byte stream and drives the physical TXD line.
//  - Format: 8N1 by default, LSB first, idle-high line.
//  - Default baud (CLK_DIV=434, ~115200 @ 50 MHz) gives a frame length of 10*434 = 4340 clocks.
//  - That frame length is shorter than the framer's 4765-clock per-byte slot, so every byte finishes inside its slot.

---
 rtl/uart_byte_tx.sv | 139 +++++++++++++
 tb/tb_uart_byte_tx.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_byte_tx.sv
// Serial UART byte transmitter: 8N1 (or 8N2), LSB first, idle-high TXD, registered outputs.
// Optional even-parity bit after D7 when UART_TX_PARITY_EN is defined.
module uart_byte_tx #(
    parameter int CLK_DIV   = 434,
    parameter int STOP_BITS = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic [7:0] DATA_IN,
    output logic       TXD,
    output logic       BUSY,
    output logic       DONE
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    localparam logic [12:0] DIV_M1    = 13'(CLK_DIV - 1);
    localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);

    state_t      r_state;
    state_t      w_next;
    logic [12:0] r_baud;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift;
    logic        r_txd;
    logic        r_busy;
    logic        r_done;
    logic        w_txd;
    logic        w_busy;
    logic        w_done;
    logic        w_bit_end;

`ifdef UART_TX_PARITY_EN
    logic        r_par;
`endif

    assign w_bit_end = (r_baud == DIV_M1);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_txd  = 1'b1;
        w_busy = 1'b1;
        w_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (START) w_next = S_START;
            end
            S_START: begin
                w_txd = 1'b0;
                if (w_bit_end) w_next = S_DATA;
            end
            S_DATA: begin
                w_txd = r_shift[0];
                if (w_bit_end && r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    w_next = S_PARITY;
`else
                    w_next = S_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                w_txd = r_par;
                if (w_bit_end) w_next = S_STOP;
            end
`endif
            S_STOP: begin
                if (w_bit_end && r_bit == STOP_LAST) begin
                    w_done = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: begin
                // Unused encodings drop straight back to an idle line.
                w_busy = 1'b0;
                w_next = S_IDLE;
            end
        endcase
    end

    // Bit counter restarts whenever the state changes, so it indexes data bits and stop bits alike.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
`ifdef UART_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else if (r_state == S_IDLE) begin
            r_baud <= '0;
            r_bit  <= '0;
            if (START) begin
                r_shift <= DATA_IN;
`ifdef UART_TX_PARITY_EN
                r_par   <= ^DATA_IN;
`endif
            end
        end else if (w_bit_end) begin
            r_baud <= '0;
            r_bit  <= (w_next != r_state) ? 3'd0 : r_bit + 3'd1;
            if (r_state == S_DATA) r_shift <= {1'b0, r_shift[7:1]};
        end else begin
            r_baud <= r_baud + 13'd1;
        end
    end

    // Outputs are registered from the current state, giving the one-clock launch latency.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_txd  <= 1'b1;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_txd  <= w_txd;
            r_busy <= w_busy;
            r_done <= w_done;
        end
    end

    assign TXD  = r_txd;
    assign BUSY = r_busy;
    assign DONE = r_done;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Self-checking bench for uart_byte_tx (CLK_DIV=4, STOP_BITS=1); expected line values come from a
// per-cycle frame model built from the bit list start/data/[parity]/stop.
module tb_uart_byte_tx;

    localparam int DIV   = 4;
    localparam int STOPB = 1;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FL = (9 + STOPB + PAR) * DIV;

    logic       CLK;
    logic       RST;
    logic       START;
    logic [7:0] DATA_IN;
    logic       TXD;
    logic       BUSY;
    logic       DONE;

    int checks = 0;
    int errors = 0;

    uart_byte_tx #(.CLK_DIV(DIV), .STOP_BITS(STOPB)) dut (
        .CLK(CLK), .RST(RST), .START(START), .DATA_IN(DATA_IN),
        .TXD(TXD), .BUSY(BUSY), .DONE(DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Line value n clocks after launch (n = 1..FL) for byte b.
    function automatic logic exp_txd(input logic [7:0] b, input int n);
        int idx;
        idx = (n - 1) / DIV;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (PAR == 1 && idx == 9) return ^b;
        return 1'b1;
    endfunction

    task automatic test_reset();
        RST = 1'b1; START = 1'b0; DATA_IN = 8'h00;
        #1;
        checks++;
        if (TXD !== 1'b1 || BUSY !== 1'b0 || DONE !== 1'b0) begin
            errors++;
            $display("FAIL reset_t0: txd=%b busy=%b done=%b, expected 1/0/0", TXD, BUSY, DONE);
        end
        repeat (3) tick();
        RST = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            checks++;
            if (TXD !== 1'b1 || BUSY !== 1'b0 || DONE !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle cyc %0d: txd=%b busy=%b done=%b, expected 1/0/0", i, TXD, BUSY, DONE);
            end
        end
    endtask

    // Launch b and check every clock of the frame plus the idle clock after it.
    task automatic test_frame(input logic [7:0] b, input string name);
        DATA_IN = b; START = 1'b1;
        tick();
        START = 1'b0;
        DATA_IN = 8'($urandom);
        for (int n = 1; n <= FL; n++) begin
            tick();
            checks++;
            if (TXD !== exp_txd(b, n) || BUSY !== 1'b1 || DONE !== (n == FL)) begin
                errors++;
                $display("FAIL %s byte %h edge %0d: txd=%b busy=%b done=%b, expected %b/1/%b",
                         name, b, n, TXD, BUSY, DONE, exp_txd(b, n), (n == FL));
            end
        end
        tick();
        checks++;
        if (TXD !== 1'b1 || BUSY !== 1'b0 || DONE !== 1'b0) begin
            errors++;
            $display("FAIL %s end: txd=%b busy=%b done=%b, expected 1/0/0", name, TXD, BUSY, DONE);
        end
    endtask

    task automatic test_data_change();
        DATA_IN = 8'h3E; START = 1'b1;
        tick();
        START = 1'b0;
        for (int n = 1; n <= FL; n++) begin
            START = (n == 10 || n == 20);
            if (n == 10) DATA_IN = 8'hFF;
            tick();
            checks++;
            if (TXD !== exp_txd(8'h3E, n) || BUSY !== 1'b1 || DONE !== (n == FL)) begin
                errors++;
                $display("FAIL data_change edge %0d: txd=%b busy=%b done=%b, expected %b/1/%b",
                         n, TXD, BUSY, DONE, exp_txd(8'h3E, n), (n == FL));
            end
        end
        START = 1'b0;
        for (int i = 0; i < 2 * DIV; i++) begin
            tick();
            checks++;
            if (TXD !== 1'b1 || BUSY !== 1'b0) begin
                errors++;
                $display("FAIL data_change no_queue cyc %0d: txd=%b busy=%b, expected 1/0", i, TXD, BUSY);
            end
        end
    endtask

    task automatic test_back_to_back();
        int p;
        int pos;
        p = FL + 1;
        DATA_IN = 8'h55; START = 1'b1;
        tick();
        for (int n = 1; n <= 3 * p; n++) begin
            if (n == 3 * p) START = 1'b0;
            tick();
            pos = n % p;
            checks++;
            if (pos == 0) begin
                if (TXD !== 1'b1 || BUSY !== 1'b0 || DONE !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b gap edge %0d: txd=%b busy=%b done=%b, expected 1/0/0", n, TXD, BUSY, DONE);
                end
            end else if (TXD !== exp_txd(8'h55, pos) || BUSY !== 1'b1 || DONE !== (pos == FL)) begin
                errors++;
                $display("FAIL b2b edge %0d: txd=%b busy=%b done=%b, expected %b/1/%b",
                         n, TXD, BUSY, DONE, exp_txd(8'h55, pos), (pos == FL));
            end
        end
        tick();
        checks++;
        if (TXD !== 1'b1 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL b2b stop: txd=%b busy=%b, expected 1/0", TXD, BUSY);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b;
        b = 8'($urandom) & 8'hF7;
        DATA_IN = b; START = 1'b1;
        tick();
        START = 1'b0;
        // Data bit 3 occupies edges 17..20 after launch.
        repeat (18) tick();
        #2;
        checks++;
        if (TXD !== 1'b0 || BUSY !== 1'b1) begin
            errors++;
            $display("FAIL midframe_pre: txd=%b busy=%b, expected 0/1", TXD, BUSY);
        end
        RST = 1'b1;
        #1;
        checks++;
        if (TXD !== 1'b1 || BUSY !== 1'b0 || DONE !== 1'b0) begin
            errors++;
            $display("FAIL midframe_async: txd=%b busy=%b done=%b, expected 1/0/0", TXD, BUSY, DONE);
        end
        tick();
        tick();
        RST = 1'b0;
        for (int i = 0; i < 3 * FL; i++) begin
            tick();
            checks++;
            if (TXD !== 1'b1 || BUSY !== 1'b0 || DONE !== 1'b0) begin
                errors++;
                $display("FAIL midframe_after cyc %0d: txd=%b busy=%b done=%b, expected 1/0/0", i, TXD, BUSY, DONE);
            end
        end
        test_frame(8'($urandom), "post_reset");
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        test_frame(8'h3E, "parity_odd_ones");
        test_frame(8'h03, "parity_even_ones");
    endtask
`endif

    initial begin
        test_reset();
        test_frame(8'h3E, "frame_3E");
        test_frame(8'h00, "frame_00");
        test_frame(8'hFF, "frame_FF");
        for (int i = 0; i < 6; i++) test_frame(8'($urandom), "frame_rand");
        test_data_change();
        test_back_to_back();
        test_reset_midframe();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
